csa_resolve: RTL
================

CSA_RESOLVE -- requirements
Module: csa_resolve

Interface
REQ-001 Parameter WIDTH, default 8: width of the carry-save operands ps and pc.
REQ-002 Parameter CHUNK, default 4: bits resolved per cycle; 1 <= CHUNK <= WIDTH+1.
REQ-003 Derived constant NCH = ceil((WIDTH+1)/CHUNK): the number of resolve cycles (3 at defaults).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  ps/pc valid.
REQ-007 in_ready  output  1  block can accept an operand pair.
REQ-008 ps  input  WIDTH  partial-sum vector (carry-save sum word).
REQ-009 pc  input  WIDTH  partial-carry vector, weight 2 relative to ps.
REQ-010 out_valid  output  1  sum holds a completed result.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 sum  output  WIDTH+2  resolved binary value, ps + 2*pc.
REQ-013 busy  output  1  high while in the BUSY state.

Function
REQ-014 Operand alignment:
- A = {1'b0, ps} and B = {pc, 1'b0}, each WIDTH+1 bits.
- Both are zero-padded to NCH*CHUNK bits.
REQ-015 Result: sum = (A + B) truncated to WIDTH+2 bits. The result is exact, so no overflow case exists.
REQ-016 FSM states:
- IDLE: in_ready=1, out_valid=0, busy=0.
- BUSY: in_ready=0, out_valid=0, busy=1.
- DONE: in_ready=0, out_valid=1, busy=0.
REQ-017 IDLE -> BUSY on a clock edge with in_valid=1:
- A and B are latched into internal registers.
- The chunk counter and carry register are cleared to 0.
REQ-018 IDLE with in_valid=0: the block stays in IDLE and sum holds its previous value.
REQ-019 Each BUSY cycle k (k = 0..NCH-1):
- Adds chunk k of A and B plus the carry register, CHUNK-bit ripple adder only.
- Writes the CHUNK result bits into the result register at bit offset k*CHUNK.
- Stores the chunk carry-out.
- Increments k.
REQ-020 On the edge that processes chunk NCH-1, the FSM moves to DONE and the full result appears on sum.
REQ-021 Latency: out_valid rises exactly NCH clock edges after the accepting edge. There is no combinational path from in_valid, ps or pc to any output.
REQ-022 DONE with out_ready=0: state, sum and out_valid hold unchanged indefinitely.
REQ-023 DONE with out_ready=1: the block returns to IDLE on that edge, and in_ready=1 from the next cycle. Throughput is one result per NCH+2 cycles at best.
REQ-024 Changes on ps, pc or in_valid while BUSY or DONE are ignored; the latched operands are not affected.
REQ-025 out_ready while in IDLE or BUSY is ignored.
REQ-026 sum is registered and is only updated during BUSY; intermediate chunk writes are visible but qualified by out_valid=0.
REQ-027 CHUNK >= WIDTH+1 gives NCH=1 and a single-cycle resolve, with identical handshake behaviour.

Reset
REQ-028 While rst=1, regardless of clk:
- FSM=IDLE, chunk counter=0, carry=0, operand registers=0, sum=0.
- out_valid=0, busy=0, in_ready=1.
REQ-029 Reset asserted mid-BUSY or mid-DONE discards the in-flight transaction. No partial result is ever flagged valid.
REQ-030 After rst deasserts, the first clock edge with in_valid=1 is accepted normally.

Verification (WIDTH=8, CHUNK=4, NCH=3)
REQ-031 Basic resolve: ps=0x00, pc=0x02 accepted -> 3 edges later out_valid=1, sum=0x004.
REQ-032 Maximum operands: ps=0xFF, pc=0xFF -> sum=0x2FD (765).
REQ-033 Full carry ripple: ps=0xFF, pc=0x01 -> sum=0x101, carry propagates through all 3 chunks.
REQ-034 Latency and ready:
- in_ready=0 for the 3 BUSY cycles plus DONE; busy=1 for exactly 3 cycles.
- Changing ps/pc during BUSY does not alter the result.
REQ-035 Backpressure:
- out_ready=0 for 5 cycles in DONE -> out_valid and sum stable.
- out_ready=1 for 1 cycle -> in_ready=1 on the next cycle, out_valid=0.
REQ-036 Reset recovery:
- rst pulsed after chunk 1 of a transaction -> IDLE, sum=0, out_valid=0, in_ready=1 immediately.
- New transaction ps=0x10, pc=0x08 -> sum=0x020.

Source files
------------

// File: rtl/csa_resolve.sv
// Resolves a carry-save pair (ps, pc) into a binary sum, CHUNK bits per cycle.
// Handshake: IDLE accepts, BUSY ripples chunks through a narrow adder, DONE holds until consumed.
module csa_resolve #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ps,
  input  logic [WIDTH-1:0] pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] sum,
  output logic             busy
);

  localparam int NCH = (WIDTH + CHUNK) / CHUNK;
  localparam int PW  = NCH * CHUNK;
  localparam int SW  = WIDTH + 2;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_stateNext;

  logic [PW-1:0]   r_a;
  logic [PW-1:0]   r_b;
  logic [CW-1:0]   r_idx;
  logic            r_carry;
  logic [SW-1:0]   r_sum;

  logic [CHUNK-1:0] w_aChunk;
  logic [CHUNK-1:0] w_bChunk;
  logic [CHUNK-1:0] w_chunkSum;
  logic [CHUNK:0]   w_ripple;
  logic [SW-1:0]    w_sumNext;
  logic             w_last;

  assign w_last = (int'(r_idx) == NCH - 1);

  // Pick the operand slice for the chunk currently being resolved.
  always_comb begin
    w_aChunk = '0;
    w_bChunk = '0;
    for (int k = 0; k < NCH; k++) begin
      if (k == int'(r_idx)) begin
        w_aChunk = r_a[k*CHUNK +: CHUNK];
        w_bChunk = r_b[k*CHUNK +: CHUNK];
      end
    end
  end

  always_comb begin
    w_chunkSum  = '0;
    w_ripple    = '0;
    w_ripple[0] = r_carry;
    for (int j = 0; j < CHUNK; j++) begin
      w_chunkSum[j]  = w_aChunk[j] ^ w_bChunk[j] ^ w_ripple[j];
      w_ripple[j+1]  = (w_aChunk[j] & w_bChunk[j]) |
                       (w_ripple[j] & (w_aChunk[j] ^ w_bChunk[j]));
    end
  end

  // When the padded operand width is exactly WIDTH+1, the final carry-out is the sum MSB.
  always_comb begin
    w_sumNext = r_sum;
    for (int i = 0; i < SW; i++) begin
      if (i / CHUNK == int'(r_idx)) begin
        w_sumNext[i] = w_chunkSum[i % CHUNK];
      end else if (i == PW && w_last) begin
        w_sumNext[i] = w_ripple[CHUNK];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_stateNext = S_BUSY;
      end
      S_BUSY: begin
        busy = 1'b1;
        if (w_last) w_stateNext = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_stateNext = S_IDLE;
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= PW'({1'b0, ps});
            r_b     <= PW'({pc, 1'b0});
            r_idx   <= '0;
            r_carry <= 1'b0;
          end
        end
        S_BUSY: begin
          r_sum   <= w_sumNext;
          r_carry <= w_ripple[CHUNK];
          r_idx   <= w_last ? '0 : r_idx + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign sum = r_sum;

endmodule
